// File: rtl/axis_wb_cmd_initiator_if.sv
// rtl/axis_wb_cmd_initiator_if.sv - command, request stream, response stream and result signals of the initiator
interface axis_wb_cmd_initiator_if #(
    parameter int WB_DATA_WIDTH = 32,
    parameter int WB_ADDR_WIDTH = 32
);
    logic                     cmd_valid;
    logic                     cmd_ready;
    logic                     cmd_write;
    logic [15:0]              cmd_tag;
    logic [WB_ADDR_WIDTH-1:0] cmd_addr;
    logic [WB_DATA_WIDTH-1:0] cmd_wdata;

    logic [7:0]               req_axis_tdata;
    logic                     req_axis_tkeep;
    logic                     req_axis_tvalid;
    logic                     req_axis_tready;
    logic                     req_axis_tlast;
    logic                     req_axis_tuser;

    logic [7:0]               rsp_axis_tdata;
    logic                     rsp_axis_tkeep;
    logic                     rsp_axis_tvalid;
    logic                     rsp_axis_tready;
    logic                     rsp_axis_tlast;
    logic                     rsp_axis_tuser;

    logic                     rsp_valid;
    logic [WB_DATA_WIDTH-1:0] rsp_rdata;
    logic [15:0]              rsp_tag;
    logic                     rsp_error;
    logic                     rsp_timeout;
    logic                     busy;

    // Initiator side
    modport master (
        input  cmd_valid, cmd_write, cmd_tag, cmd_addr, cmd_wdata,
        output cmd_ready,
        output req_axis_tdata, req_axis_tkeep, req_axis_tvalid, req_axis_tlast, req_axis_tuser,
        input  req_axis_tready,
        input  rsp_axis_tdata, rsp_axis_tkeep, rsp_axis_tvalid, rsp_axis_tlast, rsp_axis_tuser,
        output rsp_axis_tready,
        output rsp_valid, rsp_rdata, rsp_tag, rsp_error, rsp_timeout, busy
    );

    // Host / bridge side
    modport slave (
        output cmd_valid, cmd_write, cmd_tag, cmd_addr, cmd_wdata,
        input  cmd_ready,
        input  req_axis_tdata, req_axis_tkeep, req_axis_tvalid, req_axis_tlast, req_axis_tuser,
        output req_axis_tready,
        output rsp_axis_tdata, rsp_axis_tkeep, rsp_axis_tvalid, rsp_axis_tlast, rsp_axis_tuser,
        input  rsp_axis_tready,
        input  rsp_valid, rsp_rdata, rsp_tag, rsp_error, rsp_timeout, busy
    );
endinterface

// File: rtl/axis_wb_cmd_initiator.sv
// rtl/axis_wb_cmd_initiator.sv - serializes single-word commands into request frames and parses the response frame
module axis_wb_cmd_initiator #(
    parameter int         AXIS_DATA_WIDTH = 8,
    parameter int         COUNT_SIZE      = 16,
    parameter int         WB_DATA_WIDTH   = 32,
    parameter int         WB_ADDR_WIDTH   = 32,
    parameter logic [7:0] READ_REQ        = 8'hA1,
    parameter logic [7:0] WRITE_REQ       = 8'hA2,
    parameter logic [7:0] READ_RESP       = 8'hA3,
    parameter logic [7:0] WRITE_RESP      = 8'hA4,
    parameter int         TIMEOUT_CYCLES  = 1024
) (
    input  logic                     clock,
    input  logic                     reset,
    axis_wb_cmd_initiator_if.master  bus
);
    localparam int B         = AXIS_DATA_WIDTH;
    localparam int HDR_LEN   = 1 + 2 + COUNT_SIZE / B + WB_ADDR_WIDTH / B;
    localparam int DATA_LEN  = WB_DATA_WIDTH / B;
    localparam int MAX_LEN   = HDR_LEN + DATA_LEN;
    localparam int CNT_W     = $clog2(MAX_LEN + 1);
    localparam int HDR_BITS  = HDR_LEN * B;
    localparam int TX_BITS   = MAX_LEN * B;
    localparam int TMO_W     = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

    localparam logic [CNT_W-1:0] HDR_CNT   = CNT_W'(HDR_LEN);
    localparam logic [CNT_W-1:0] SHORT_END = CNT_W'(HDR_LEN - 1);
    localparam logic [CNT_W-1:0] LONG_END  = CNT_W'(MAX_LEN - 1);
    localparam logic [TMO_W-1:0] TMO_LAST  = TMO_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

    typedef enum logic [2:0] {S_IDLE, S_TX, S_RX, S_DRAIN, S_DONE} state_t;

    state_t                   state, state_next;
    logic                     cap_write;
    logic [15:0]              cap_tag;
    logic [TX_BITS-1:0]       tx_shift;
    logic [HDR_BITS-1:0]      rx_shift;
    logic [CNT_W-1:0]         byte_cnt;
    logic [TMO_W-1:0]         tmo_cnt;
    logic                     err_q;
    logic [WB_DATA_WIDTH-1:0] rdata_acc;
    logic [WB_DATA_WIDTH-1:0] rsp_rdata_q;
    logic [15:0]              rsp_tag_q;
    logic                     rsp_error_q;
    logic                     rsp_timeout_q;

    logic                     cmd_ready_c;
    logic                     cmd_fire;
    logic                     tx_fire;
    logic                     tx_last;
    logic                     rx_state;
    logic                     rx_fire;
    logic                     rx_last;
    logic                     in_hdr;
    logic                     tmo_hit;
    logic                     rx_beat_err;
    logic                     err_next;
    logic                     done_enter;
    logic                     rx_data_beat;
    logic [WB_DATA_WIDTH-1:0] rdata_next;
    logic [B-1:0]             rx_byte;
    logic                     unused_inputs;

    assign unused_inputs = bus.rsp_axis_tkeep;

    assign rx_byte      = B'(bus.rsp_axis_tdata);
    assign cmd_ready_c  = reset && (state == S_IDLE);
    assign cmd_fire     = bus.cmd_valid && cmd_ready_c;
    assign tx_fire      = (state == S_TX) && bus.req_axis_tready;
    assign tx_last      = byte_cnt == (cap_write ? LONG_END : SHORT_END);
    assign rx_state     = (state == S_RX) || (state == S_DRAIN);
    assign rx_fire      = rx_state && bus.rsp_axis_tvalid;
    assign rx_last      = byte_cnt == (cap_write ? SHORT_END : LONG_END);
    assign in_hdr       = byte_cnt < HDR_CNT;
    assign tmo_hit      = (TIMEOUT_CYCLES != 0) && rx_state && !rx_fire && (tmo_cnt == TMO_LAST);
    assign err_next     = err_q || (rx_fire && rx_beat_err);
    assign done_enter   = rx_state && (state_next == S_DONE);
    assign rx_data_beat = rx_fire && (state == S_RX) && !in_hdr;
    assign rdata_next   = rx_data_beat ? ((rdata_acc << B) | WB_DATA_WIDTH'(rx_byte)) : rdata_acc;

    // A missing or premature tlast both show up as tlast disagreeing with the expected final position.
    always_comb begin : rx_check
        rx_beat_err = 1'b0;
        if (state == S_RX) begin
            rx_beat_err = (in_hdr && (rx_byte != rx_shift[HDR_BITS-1 -: B]))
                       || (bus.rsp_axis_tlast != rx_last)
                       || (bus.rsp_axis_tlast && bus.rsp_axis_tuser);
        end else if (state == S_DRAIN) begin
            rx_beat_err = bus.rsp_axis_tlast && bus.rsp_axis_tuser;
        end
    end

    always_ff @(posedge clock or negedge reset) begin : state_reg
        if (!reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin : next_state_logic
        state_next = state;
        case (state)
            S_IDLE:  if (cmd_fire) state_next = S_TX;
            S_TX:    if (tx_fire && tx_last) state_next = S_RX;
            S_RX: begin
                if (rx_fire) begin
                    if (bus.rsp_axis_tlast) state_next = S_DONE;
                    else if (rx_last)       state_next = S_DRAIN;
                end else if (tmo_hit) begin
                    state_next = S_DONE;
                end
            end
            S_DRAIN: begin
                if (rx_fire) begin
                    if (bus.rsp_axis_tlast) state_next = S_DONE;
                end else if (tmo_hit) begin
                    state_next = S_DONE;
                end
            end
            S_DONE:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_comb begin : output_logic
        bus.cmd_ready       = cmd_ready_c;
        bus.req_axis_tvalid = (state == S_TX);
        bus.req_axis_tdata  = 8'h00;
        bus.req_axis_tlast  = 1'b0;
        bus.req_axis_tkeep  = 1'b1;
        bus.req_axis_tuser  = 1'b0;
        bus.rsp_axis_tready = reset && ((state == S_IDLE) || rx_state);
        bus.rsp_valid       = (state == S_DONE);
        bus.busy            = (state != S_IDLE);
        if (state == S_TX) begin
            bus.req_axis_tdata = 8'(tx_shift[TX_BITS-1 -: B]);
            bus.req_axis_tlast = tx_last;
        end
    end

    assign bus.rsp_rdata   = rsp_rdata_q;
    assign bus.rsp_tag     = rsp_tag_q;
    assign bus.rsp_error   = rsp_error_q;
    assign bus.rsp_timeout = rsp_timeout_q;

    // Both frames are preloaded as shift registers at capture so each beat only looks at the top byte.
    always_ff @(posedge clock or negedge reset) begin : datapath
        if (!reset) begin
            cap_write     <= 1'b0;
            cap_tag       <= '0;
            tx_shift      <= '0;
            rx_shift      <= '0;
            byte_cnt      <= '0;
            tmo_cnt       <= '0;
            err_q         <= 1'b0;
            rdata_acc     <= '0;
            rsp_rdata_q   <= '0;
            rsp_tag_q     <= '0;
            rsp_error_q   <= 1'b0;
            rsp_timeout_q <= 1'b0;
        end else begin
            if (cmd_fire) begin
                cap_write <= bus.cmd_write;
                cap_tag   <= bus.cmd_tag;
                tx_shift  <= {(bus.cmd_write ? WRITE_REQ : READ_REQ), bus.cmd_tag,
                              COUNT_SIZE'(1), bus.cmd_addr, bus.cmd_wdata};
                rx_shift  <= {(bus.cmd_write ? WRITE_RESP : READ_RESP), bus.cmd_tag,
                              COUNT_SIZE'(1), bus.cmd_addr};
                byte_cnt  <= '0;
                err_q     <= 1'b0;
                rdata_acc <= '0;
            end

            if (tx_fire) begin
                tx_shift <= tx_shift << B;
                byte_cnt <= tx_last ? '0 : byte_cnt + 1'b1;
                tmo_cnt  <= '0;
            end

            if (rx_state) begin
                tmo_cnt <= rx_fire ? '0 : tmo_cnt + 1'b1;
            end

            if (rx_fire) begin
                err_q <= err_next;
                if (state == S_RX) begin
                    byte_cnt  <= byte_cnt + 1'b1;
                    rx_shift  <= rx_shift << B;
                    rdata_acc <= rdata_next;
                end
            end

            if (done_enter) begin
                rsp_tag_q     <= cap_tag;
                rsp_error_q   <= err_next || tmo_hit;
                rsp_timeout_q <= tmo_hit;
                rsp_rdata_q   <= (tmo_hit || cap_write) ? '0 : rdata_next;
            end
        end
    end
endmodule

// File: tb/tb_axis_wb_cmd_initiator.sv
// tb/tb_axis_wb_cmd_initiator.sv - directed self-checking bench for axis_wb_cmd_initiator
module tb_axis_wb_cmd_initiator;
    localparam int TMO = 16;

    logic clock = 1'b0;
    logic reset = 1'b0;
    always #5 clock = ~clock;

    axis_wb_cmd_initiator_if #(.WB_DATA_WIDTH(32), .WB_ADDR_WIDTH(32)) bus ();

    axis_wb_cmd_initiator #(.TIMEOUT_CYCLES(TMO)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    int vectors = 0;
    int miscompares = 0;

    logic [7:0] got[$];
    logic [7:0] rsp_q[$];
    int         last_pos;
    int         holds;
    bit         stuck;

    task automatic drive_idle();
        bus.cmd_valid       = 1'b0;
        bus.cmd_write       = 1'b0;
        bus.cmd_tag         = 16'h0;
        bus.cmd_addr        = 32'h0;
        bus.cmd_wdata       = 32'h0;
        bus.req_axis_tready = 1'b0;
        bus.rsp_axis_tdata  = 8'h0;
        bus.rsp_axis_tkeep  = 1'b1;
        bus.rsp_axis_tvalid = 1'b0;
        bus.rsp_axis_tlast  = 1'b0;
        bus.rsp_axis_tuser  = 1'b0;
    endtask

    task automatic issue_cmd(input logic wr, input logic [15:0] tag, input logic [31:0] addr,
                             input logic [31:0] wdata);
        @(negedge clock);
        bus.cmd_valid = 1'b1;
        bus.cmd_write = wr;
        bus.cmd_tag   = tag;
        bus.cmd_addr  = addr;
        bus.cmd_wdata = wdata;
        @(negedge clock);
        bus.cmd_valid = 1'b0;
    endtask

    // Records accepted request bytes; returns at the negedge before the final handshake edge.
    task automatic collect_req(input bit toggle);
        bit         prev_stall;
        logic [7:0] prev_byte;
        got.delete();
        last_pos   = -1;
        holds      = 0;
        prev_stall = 1'b0;
        prev_byte  = 8'h0;
        for (int cyc = 0; cyc < 200; cyc++) begin
            if (cyc > 0) @(negedge clock);
            bus.req_axis_tready = toggle ? ((cyc % 2) == 0) : 1'b1;
            if (prev_stall && (!bus.req_axis_tvalid || bus.req_axis_tdata !== prev_byte)) holds++;
            if (bus.req_axis_tvalid && bus.req_axis_tready) begin
                got.push_back(bus.req_axis_tdata);
                prev_stall = 1'b0;
                if (bus.req_axis_tlast) begin
                    last_pos = got.size();
                    break;
                end
            end else begin
                prev_stall = bus.req_axis_tvalid;
                prev_byte  = bus.req_axis_tdata;
            end
        end
    endtask

    task automatic push_be(input logic [31:0] v, input int nbytes);
        for (int i = nbytes - 1; i >= 0; i--) rsp_q.push_back(v[i*8 +: 8]);
    endtask

    task automatic build_rsp(input logic [7:0] typ, input logic [15:0] tag, input logic [31:0] addr,
                             input bit with_data, input logic [31:0] data);
        rsp_q.delete();
        push_be({24'h0, typ}, 1);
        push_be({16'h0, tag}, 2);
        push_be(32'h1, 2);
        push_be(addr, 4);
        if (with_data) push_be(data, 4);
    endtask

    // Sends rsp_q with tlast on its final byte; returns at the negedge after the final accept.
    task automatic send_rsp(input bit tuser_last);
        int n;
        n = rsp_q.size();
        stuck = 1'b0;
        for (int i = 0; i < n; i++) begin
            @(negedge clock);
            bus.rsp_axis_tvalid = 1'b1;
            bus.rsp_axis_tdata  = rsp_q[i];
            bus.rsp_axis_tlast  = (i == n - 1);
            bus.rsp_axis_tuser  = (i == n - 1) && tuser_last;
            for (int w = 0; w < 50 && !bus.rsp_axis_tready; w++) @(negedge clock);
            if (!bus.rsp_axis_tready) stuck = 1'b1;
        end
        @(negedge clock);
        bus.rsp_axis_tvalid = 1'b0;
        bus.rsp_axis_tlast  = 1'b0;
        bus.rsp_axis_tuser  = 1'b0;
    endtask

    task automatic test_reset();
        drive_idle();
        reset = 1'b0;
        repeat (2) @(negedge clock);
        vectors++; if (bus.cmd_ready !== 1'b0) begin $display("FAIL reset_cmd_ready got=%b exp=0", bus.cmd_ready); miscompares++; end
        vectors++; if (bus.req_axis_tvalid !== 1'b0) begin $display("FAIL reset_tvalid got=%b exp=0", bus.req_axis_tvalid); miscompares++; end
        vectors++; if (bus.req_axis_tkeep !== 1'b1) begin $display("FAIL reset_tkeep got=%b exp=1", bus.req_axis_tkeep); miscompares++; end
        vectors++; if (bus.rsp_axis_tready !== 1'b0) begin $display("FAIL reset_rsp_tready got=%b exp=0", bus.rsp_axis_tready); miscompares++; end
        vectors++; if ({bus.rsp_valid, bus.busy, bus.rsp_error, bus.rsp_timeout} !== 4'b0) begin
            $display("FAIL reset_flags got=%b exp=0000", {bus.rsp_valid, bus.busy, bus.rsp_error, bus.rsp_timeout}); miscompares++; end
        vectors++; if (bus.rsp_rdata !== 32'h0 || bus.rsp_tag !== 16'h0) begin
            $display("FAIL reset_result got=%h/%h exp=0/0", bus.rsp_rdata, bus.rsp_tag); miscompares++; end
        reset = 1'b1;
        @(negedge clock);
        vectors++; if (bus.cmd_ready !== 1'b1) begin $display("FAIL idle_cmd_ready got=%b exp=1", bus.cmd_ready); miscompares++; end
    endtask

    task automatic check_write_frame(input string name);
        logic [103:0] exp_frame;
        exp_frame = 104'hA2_0005_0001_00001000_DEADBEEF;
        vectors++; if (got.size() !== 13) begin $display("FAIL %s_len got=%0d exp=13", name, got.size()); miscompares++; end
        vectors++; if (last_pos !== 13) begin $display("FAIL %s_tlast_pos got=%0d exp=13", name, last_pos); miscompares++; end
        for (int i = 0; i < 13 && i < got.size(); i++) begin
            vectors++;
            if (got[i] !== exp_frame[(12-i)*8 +: 8]) begin
                $display("FAIL %s_byte%0d got=%h exp=%h", name, i, got[i], exp_frame[(12-i)*8 +: 8]); miscompares++;
            end
        end
    endtask

    task automatic test_write();
        issue_cmd(1'b1, 16'h0005, 32'h0000_1000, 32'hDEAD_BEEF);
        vectors++; if (bus.busy !== 1'b1 || bus.cmd_ready !== 1'b0) begin
            $display("FAIL write_busy got=%b/%b exp=1/0", bus.busy, bus.cmd_ready); miscompares++; end
        collect_req(1'b0);
        check_write_frame("write");
        build_rsp(8'hA4, 16'h0005, 32'h0000_1000, 1'b0, 32'h0);
        send_rsp(1'b0);
        vectors++; if (stuck !== 1'b0) begin $display("FAIL write_rsp_stuck got=%b exp=0", stuck); miscompares++; end
        vectors++; if (bus.rsp_valid !== 1'b1) begin $display("FAIL write_rsp_valid got=%b exp=1", bus.rsp_valid); miscompares++; end
        vectors++; if ({bus.rsp_error, bus.rsp_timeout} !== 2'b00) begin
            $display("FAIL write_rsp_status got=%b exp=00", {bus.rsp_error, bus.rsp_timeout}); miscompares++; end
        vectors++; if (bus.rsp_tag !== 16'h0005 || bus.rsp_rdata !== 32'h0) begin
            $display("FAIL write_rsp_result got=%h/%h exp=0005/00000000", bus.rsp_tag, bus.rsp_rdata); miscompares++; end
        @(negedge clock);
        vectors++; if (bus.rsp_valid !== 1'b0 || bus.cmd_ready !== 1'b1 || bus.rsp_tag !== 16'h0005) begin
            $display("FAIL write_after_done got=%b/%b/%h exp=0/1/0005", bus.rsp_valid, bus.cmd_ready, bus.rsp_tag); miscompares++; end
    endtask

    task automatic test_read();
        logic [71:0] exp_frame;
        exp_frame = 72'hA1_1234_0001_00000020;
        issue_cmd(1'b0, 16'h1234, 32'h0000_0020, 32'hFFFF_FFFF);
        collect_req(1'b0);
        vectors++; if (got.size() !== 9 || last_pos !== 9) begin
            $display("FAIL read_len got=%0d/%0d exp=9/9", got.size(), last_pos); miscompares++; end
        for (int i = 0; i < 9 && i < got.size(); i++) begin
            vectors++;
            if (got[i] !== exp_frame[(8-i)*8 +: 8]) begin
                $display("FAIL read_byte%0d got=%h exp=%h", i, got[i], exp_frame[(8-i)*8 +: 8]); miscompares++;
            end
        end
        build_rsp(8'hA3, 16'h1234, 32'h0000_0020, 1'b1, 32'hCAFE_BABE);
        send_rsp(1'b0);
        vectors++; if (stuck !== 1'b0 || bus.rsp_valid !== 1'b1) begin
            $display("FAIL read_rsp_valid got=%b stuck=%b exp=1", bus.rsp_valid, stuck); miscompares++; end
        vectors++; if (bus.rsp_rdata !== 32'hCAFE_BABE || bus.rsp_error !== 1'b0 || bus.rsp_tag !== 16'h1234) begin
            $display("FAIL read_rsp got=%h err=%b tag=%h exp=cafebabe/0/1234", bus.rsp_rdata, bus.rsp_error, bus.rsp_tag); miscompares++; end
    endtask

    task automatic test_tready_toggle();
        issue_cmd(1'b1, 16'h0005, 32'h0000_1000, 32'hDEAD_BEEF);
        collect_req(1'b1);
        check_write_frame("toggle");
        vectors++; if (holds !== 0) begin $display("FAIL toggle_hold got=%0d exp=0", holds); miscompares++; end
        build_rsp(8'hA4, 16'h0005, 32'h0000_1000, 1'b0, 32'h0);
        send_rsp(1'b0);
        vectors++; if (bus.rsp_valid !== 1'b1 || bus.rsp_error !== 1'b0) begin
            $display("FAIL toggle_rsp got=%b/%b exp=1/0", bus.rsp_valid, bus.rsp_error); miscompares++; end
    endtask

    task automatic test_rsp_errors();
        issue_cmd(1'b0, 16'h1234, 32'h0000_0020, 32'h0);
        collect_req(1'b0);
        build_rsp(8'hA3, 16'h1235, 32'h0000_0020, 1'b1, 32'hCAFE_BABE);
        send_rsp(1'b0);
        vectors++; if (bus.rsp_valid !== 1'b1 || bus.rsp_error !== 1'b1 || bus.rsp_rdata !== 32'hCAFE_BABE) begin
            $display("FAIL bad_tag got=%b/%b/%h exp=1/1/cafebabe", bus.rsp_valid, bus.rsp_error, bus.rsp_rdata); miscompares++; end

        issue_cmd(1'b0, 16'h1234, 32'h0000_0020, 32'h0);
        collect_req(1'b0);
        build_rsp(8'hA3, 16'h1234, 32'h0000_0020, 1'b1, 32'h0123_4567);
        send_rsp(1'b1);
        vectors++; if (bus.rsp_valid !== 1'b1 || bus.rsp_error !== 1'b1 || bus.rsp_rdata !== 32'h0123_4567) begin
            $display("FAIL tuser_err got=%b/%b/%h exp=1/1/01234567", bus.rsp_valid, bus.rsp_error, bus.rsp_rdata); miscompares++; end

        issue_cmd(1'b0, 16'h00AA, 32'h0000_0044, 32'h0);
        collect_req(1'b0);
        build_rsp(8'hA3, 16'h00AA, 32'h0000_0044, 1'b0, 32'h0);
        send_rsp(1'b0);
        vectors++; if (bus.rsp_valid !== 1'b1 || bus.rsp_error !== 1'b1 || bus.rsp_tag !== 16'h00AA) begin
            $display("FAIL early_tlast got=%b/%b/%h exp=1/1/00aa", bus.rsp_valid, bus.rsp_error, bus.rsp_tag); miscompares++; end
    endtask

    task automatic test_drain();
        issue_cmd(1'b0, 16'h0042, 32'h0000_0020, 32'h0);
        collect_req(1'b0);
        build_rsp(8'hA3, 16'h0042, 32'h0000_0020, 1'b1, 32'hCAFE_BABE);
        push_be(32'h0011_2233, 3);
        send_rsp(1'b0);
        vectors++; if (stuck !== 1'b0) begin $display("FAIL drain_stuck got=%b exp=0", stuck); miscompares++; end
        vectors++; if (bus.rsp_valid !== 1'b1 || bus.rsp_error !== 1'b1 || bus.rsp_rdata !== 32'hCAFE_BABE) begin
            $display("FAIL drain_rsp got=%b/%b/%h exp=1/1/cafebabe", bus.rsp_valid, bus.rsp_error, bus.rsp_rdata); miscompares++; end

        issue_cmd(1'b0, 16'h0043, 32'h0000_0024, 32'h0);
        collect_req(1'b0);
        build_rsp(8'hA3, 16'h0043, 32'h0000_0024, 1'b1, 32'h0BAD_F00D);
        send_rsp(1'b0);
        vectors++; if (bus.rsp_valid !== 1'b1 || bus.rsp_error !== 1'b0 || bus.rsp_rdata !== 32'h0BAD_F00D) begin
            $display("FAIL after_drain got=%b/%b/%h exp=1/0/0badf00d", bus.rsp_valid, bus.rsp_error, bus.rsp_rdata); miscompares++; end
    endtask

    task automatic test_timeout();
        int k;
        issue_cmd(1'b1, 16'h0077, 32'h0000_0100, 32'h5555_AAAA);
        collect_req(1'b0);
        k = 0;
        for (int c = 1; c <= 100; c++) begin
            @(negedge clock);
            if (bus.rsp_valid) begin k = c; break; end
        end
        // k counts negedges from the one following the final request handshake edge
        vectors++; if (k - 1 !== TMO) begin $display("FAIL timeout_latency got=%0d exp=%0d", k - 1, TMO); miscompares++; end
        vectors++; if ({bus.rsp_timeout, bus.rsp_error} !== 2'b11 || bus.rsp_rdata !== 32'h0 || bus.rsp_tag !== 16'h0077) begin
            $display("FAIL timeout_rsp got=%b/%h/%h exp=11/00000000/0077", {bus.rsp_timeout, bus.rsp_error}, bus.rsp_rdata, bus.rsp_tag); miscompares++; end

        @(negedge clock);
        bus.rsp_axis_tvalid = 1'b1;
        bus.rsp_axis_tdata  = 8'hA4;
        bus.rsp_axis_tlast  = 1'b1;
        vectors++; if (bus.rsp_axis_tready !== 1'b1 || bus.cmd_ready !== 1'b1) begin
            $display("FAIL stale_drop got=%b/%b exp=1/1", bus.rsp_axis_tready, bus.cmd_ready); miscompares++; end
        @(negedge clock);
        bus.rsp_axis_tvalid = 1'b0;
        bus.rsp_axis_tlast  = 1'b0;

        issue_cmd(1'b0, 16'h0078, 32'h0000_0104, 32'h0);
        collect_req(1'b0);
        build_rsp(8'hA3, 16'h0078, 32'h0000_0104, 1'b1, 32'h1357_9BDF);
        send_rsp(1'b0);
        vectors++; if (bus.rsp_valid !== 1'b1 || {bus.rsp_error, bus.rsp_timeout} !== 2'b00 || bus.rsp_rdata !== 32'h1357_9BDF) begin
            $display("FAIL after_timeout got=%b/%b/%h exp=1/00/13579bdf", bus.rsp_valid, {bus.rsp_error, bus.rsp_timeout}, bus.rsp_rdata); miscompares++; end
    endtask

    task automatic test_reset_mid_tx();
        issue_cmd(1'b1, 16'h0099, 32'h0000_2000, 32'h1111_2222);
        bus.req_axis_tready = 1'b0;
        repeat (3) @(negedge clock);
        vectors++; if (bus.req_axis_tvalid !== 1'b1) begin $display("FAIL stall_tvalid got=%b exp=1", bus.req_axis_tvalid); miscompares++; end
        #2 reset = 1'b0;
        #1;
        vectors++; if (bus.req_axis_tvalid !== 1'b0 || bus.busy !== 1'b0) begin
            $display("FAIL async_reset got=%b/%b exp=0/0", bus.req_axis_tvalid, bus.busy); miscompares++; end
        @(negedge clock);
        reset = 1'b1;
        bus.req_axis_tready = 1'b1;
        @(negedge clock);
        vectors++; if (bus.req_axis_tvalid !== 1'b0 || bus.cmd_ready !== 1'b1) begin
            $display("FAIL post_reset got=%b/%b exp=0/1", bus.req_axis_tvalid, bus.cmd_ready); miscompares++; end
        issue_cmd(1'b0, 16'h1234, 32'h0000_0020, 32'h0);
        collect_req(1'b0);
        vectors++; if (got.size() !== 9 || got[0] !== 8'hA1) begin
            $display("FAIL post_reset_frame got=%0d first byte mismatch exp=9/a1", got.size()); miscompares++; end
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_tready_toggle();
        test_rsp_errors();
        test_drain();
        test_timeout();
        test_reset_mid_tx();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end
endmodule
